uart_receiver: RTL
==================

// Module: uart_receiver
// PURPOSE
//  Serial-to-parallel UART receiver; the receive end of the 8N1-style link driven by uart_transmitter.
//  Synchronises the async rx line, finds start bits, samples data LSB-first at mid-bit, checks the stop bit.
//  Presents each frame on a valid/ready holding register.
//  Sits between the board rx pin and the command/data ingest logic of the TPU host interface.
// PARAMETERS
//  UART_BITS_TRANSFERED  8   data bits per frame (1..16)
//  CLKS_PER_BIT          16  clk cycles per serial bit; even, >= 4
// PORTS
//  clk        in   1                     system clock; all logic on posedge
//  rst        in   1                     asynchronous, active-low reset (asserted when 0)
//  rx         in   1                     async serial input; idles high
//  message    out  UART_BITS_TRANSFERED  received data word; bit 0 = first bit on the line
//  valid      out  1                     message holds an unconsumed frame
//  ready      in   1                     consumer accepts message when valid & ready
//  frame_err  out  1                     1-cycle pulse: stop bit sampled as 0
//  overrun    out  1                     1-cycle pulse: frame completed while holding reg still full
//  busy       out  1                     1 while state != IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, counters=0, message=0, valid=0, frame_err=0, overrun=0, busy=0.
//   2-FF synchroniser and rx_prev reset to 1. Reset mid-frame aborts the frame silently; no flags.
//  Synchroniser: rx -> s1 -> s2 (rx_s). rx_prev <= rx_s every cycle. All decisions use rx_s.
//  FSM states IDLE, START, DATA, STOP; one cycle counter cnt and bit index idx:
//   IDLE:  falling edge (rx_prev=1, rx_s=0) -> START, cnt=0. A level-low line with no edge
//          (break, stuck-low) does not start a frame.
//   START: cnt counts up; at cnt==CLKS_PER_BIT/2-1 (mid start bit): rx_s=0 -> DATA, cnt=0, idx=0.
//          rx_s=1 -> IDLE (glitch reject, no flags).
//   DATA:  at cnt==CLKS_PER_BIT-1: shift rx_s into bit idx, cnt=0, idx+1.
//          After bit UART_BITS_TRANSFERED-1 is taken -> STOP. Otherwise cnt+1.
//   STOP:  at cnt==CLKS_PER_BIT-1 sample rx_s, then -> IDLE the same cycle.
//          rx_s=1: frame good, goes to holding reg. rx_s=0: frame_err pulses next cycle; data discarded.
//  Holding register (updated cycle after good stop sample; valid/message visible then):
//   valid=0: message<=shift reg, valid<=1.
//   valid=1 and ready=1 in that cycle: old word consumed; new word loaded; valid stays 1; no overrun.
//   valid=1 and ready=0: new word dropped, message unchanged, overrun pulses 1 cycle.
//   Otherwise valid & ready clears valid next cycle. message only changes on load; stable while valid.
//  Latency: falling edge on rx to valid high =
//   2 (sync) + CLKS_PER_BIT/2 + (UART_BITS_TRANSFERED+1)*CLKS_PER_BIT + 1 cycles.
//  Re-arm: IDLE entered mid-stop-bit; next start edge detected immediately, giving back-to-back frames.
//  frame_err and overrun never assert together; neither affects valid.
//  Counter widths: $clog2(CLKS_PER_BIT) and $clog2(UART_BITS_TRANSFERED+1); no wrap beyond terminal counts.
// TESTING  (CLKS_PER_BIT=16, UART_BITS_TRANSFERED=8)
//  1 Drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> message=8'hA5, valid=1 at edge+155 cycles;
//    valid holds until a ready pulse, then 0 next cycle.
//  2 rx low for 4 cycles, then high -> busy 1 then 0 by ~edge+10; valid, frame_err, overrun stay 0.
//  3 Frame 0x3C with stop bit driven 0 -> frame_err single-cycle pulse; valid stays 0; message unchanged.
//    Holding rx low afterwards starts no new frame.
//  4 Frames 0x11 then 0x22, ready=0 -> message=0x11, overrun pulses once after 2nd frame;
//    ready=1 -> valid falls, message still 0x11.
//  5 Back-to-back 0x55,0xAA; ready=1 at the 2nd load cycle -> message 0x55 then 0xAA; valid stays high; no overrun.
//  6 rst=0 asynchronously at DATA bit 3 -> all outputs 0 immediately;
//    release, send 0x0F -> message=0x0F, valid=1, no flags.

Source files
------------

// File: rtl/uart_receiver_if.sv
// Receiver-to-consumer link: received word on a valid/ready holding register plus status pulses.
interface uart_receiver_if #(
    parameter int unsigned UART_BITS_TRANSFERED = 8
);

    logic [UART_BITS_TRANSFERED-1:0] message;
    logic                            valid;
    logic                            ready;
    logic                            frame_err;
    logic                            overrun;
    logic                            busy;

    // Receiver side: produces the word and status, observes ready.
    modport master (
        output message,
        output valid,
        output frame_err,
        output overrun,
        output busy,
        input  ready
    );

    // Consumer side: observes the word and status, drives ready.
    modport slave (
        input  message,
        input  valid,
        input  frame_err,
        input  overrun,
        input  busy,
        output ready
    );

endinterface

// File: rtl/uart_receiver.sv
// UART receiver: synchronises rx, detects start edges, samples data LSB-first at mid-bit,
// checks the stop bit and presents each good frame on a valid/ready holding register.
module uart_receiver #(
    parameter int unsigned UART_BITS_TRANSFERED = 8,
    parameter int unsigned CLKS_PER_BIT         = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx,
    uart_receiver_if.master bus
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(UART_BITS_TRANSFERED + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_BITS_TRANSFERED - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e state_q, state_d;

    logic                            s1_q, s2_q, rx_prev_q;
    logic                            rx_s;
    logic                            start_edge;

    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic                            cnt_mid, cnt_last, idx_last;

    logic [UART_BITS_TRANSFERED-1:0] shift_q, shift_next;
    logic [UART_BITS_TRANSFERED-1:0] message_q;
    logic                            valid_q, frame_err_q, overrun_q;

    // FSM-decoded strobes
    logic                            busy;
    logic                            cnt_run;
    logic                            cnt_term;
    logic                            idx_clr;
    logic                            shift_en;
    logic                            stop_good;
    logic                            stop_bad;

    assign rx_s       = s2_q;
    // Only a high-to-low transition starts a frame; a line held low never re-triggers.
    assign start_edge = rx_prev_q & ~rx_s;

    assign cnt_mid  = (cnt_q == CNT_MID);
    assign cnt_last = (cnt_q == CNT_LAST);
    assign idx_last = (idx_q == IDX_LAST);

    // Two-flop synchroniser plus one-cycle history for edge detection; idles high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            s1_q      <= rx;
            s2_q      <= s1_q;
            rx_prev_q <= s2_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_edge) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                // Start bit must still be low at its midpoint, otherwise treat it as a glitch.
                if (cnt_mid) begin
                    state_d = rx_s ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_last && idx_last) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                // Leave mid-stop-bit so the next start edge is caught immediately.
                if (cnt_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM output decode: busy flag and datapath strobes.
    always_comb begin
        busy      = 1'b1;
        cnt_run   = 1'b0;
        cnt_term  = 1'b0;
        idx_clr   = 1'b0;
        shift_en  = 1'b0;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
            end
            StStart: begin
                cnt_run  = 1'b1;
                cnt_term = cnt_mid;
                idx_clr  = cnt_mid;
            end
            StData: begin
                cnt_run  = 1'b1;
                cnt_term = cnt_last;
                shift_en = cnt_last;
            end
            StStop: begin
                cnt_run   = 1'b1;
                cnt_term  = cnt_last;
                stop_good = cnt_last & rx_s;
                stop_bad  = cnt_last & ~rx_s;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Counter next values: cycle counter restarts at each terminal count, bit index saturates at N.
    always_comb begin
        cnt_d = '0;
        if (cnt_run && !cnt_term) begin
            cnt_d = cnt_q + 1'b1;
        end
        idx_d = idx_q;
        if (idx_clr) begin
            idx_d = '0;
        end else if (shift_en) begin
            idx_d = idx_q + 1'b1;
        end
    end

    // Cycle counter and bit index registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // Right-shifting in at the top leaves the first received bit in bit 0 after N shifts.
    if (UART_BITS_TRANSFERED == 1) begin : g_shift_one
        assign shift_next = rx_s;
    end else begin : g_shift_multi
        assign shift_next = {rx_s, shift_q[UART_BITS_TRANSFERED-1:1]};
    end

    // Data shift register, loaded once per data bit at mid-bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
        end else if (shift_en) begin
            shift_q <= shift_next;
        end
    end

    // Holding register with valid/ready handshake and one-cycle status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            message_q   <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= stop_bad;
            overrun_q   <= 1'b0;
            if (stop_good) begin
                // A consume in the same cycle frees the slot for the new word.
                if (!valid_q || bus.ready) begin
                    message_q <= shift_q;
                    valid_q   <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && bus.ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.message   = message_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = busy;

endmodule
